// File: rtl/led_status_pkg.sv
// led_status_pkg: shared mode encoding for the LED status engine
package led_status_pkg;
   localparam int MODE_W = 2;
   typedef enum logic [MODE_W-1:0] {LED_OFF, LED_SOLID, LED_BLINK, LED_BREATHE} led_mode_e;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel with shadowed config, blink/breathe sequencing and PWM compare (LED_GAMMA_EN adds gamma stage)
import led_status_pkg::*;
module led_pwm_channel #(
   parameter int PWM_BITS       = 8,
   parameter int BLINK_FRAMES   = 250,
   parameter int BREATHE_FRAMES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_bnd,
   input  logic                we,
   input  led_mode_e           mode,
   input  logic [PWM_BITS-1:0] level,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                pending,
   output logic                pwm
);
   localparam int FMAX = BLINK_FRAMES > BREATHE_FRAMES ? BLINK_FRAMES : BREATHE_FRAMES;
   localparam int FC_W = FMAX > 1 ? $clog2(FMAX) : 1;
   localparam logic [FC_W-1:0] BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
   localparam logic [FC_W-1:0] BREATHE_LAST = FC_W'(BREATHE_FRAMES - 1);
   localparam logic [PWM_BITS-1:0] DMAX = '1;
   led_mode_e sh_mode, act_mode;
   logic [PWM_BITS-1:0] sh_level, act_level, ramp, ramp_nxt, duty;
   logic [FC_W-1:0] fcnt;
   logic phase, ramp_dn, dn_nxt, frame_wrap;
   // duty follows registered state, so it only moves at frame boundaries; ramp steps as a triangle
   always_comb begin
      duty = act_mode == LED_SOLID ? act_level :
             act_mode == LED_BLINK ? (phase ? '0 : act_level) :
             act_mode == LED_BREATHE ? ramp : '0;
      frame_wrap = fcnt == (act_mode == LED_BLINK ? BLINK_LAST : BREATHE_LAST);
      dn_nxt = ramp_dn ? ramp != '0 : ramp >= act_level;
      ramp_nxt = dn_nxt ? ramp - PWM_BITS'(ramp != '0) : ramp + PWM_BITS'(ramp < act_level);
   end
   // shadow capture, boundary apply and per-frame blink/breathe advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_mode <= LED_OFF;
         sh_level <= '0;
         act_mode <= LED_OFF;
         act_level <= '0;
         pending <= 1'b0;
         phase <= 1'b0;
         fcnt <= '0;
         ramp <= '0;
         ramp_dn <= 1'b0;
      end else begin
         if (we) begin
            sh_mode <= mode;
            sh_level <= level;
            pending <= 1'b1;
         end
         if (frame_bnd && pending) begin
            act_mode <= sh_mode;
            act_level <= sh_level;
            pending <= 1'b0;
            phase <= 1'b0;
            fcnt <= '0;
            ramp <= '0;
            ramp_dn <= 1'b0;
         end else if (frame_bnd) begin
            fcnt <= frame_wrap ? '0 : fcnt + 1'b1;
            if (frame_wrap && act_mode == LED_BLINK) phase <= ~phase;
            if (frame_wrap && act_mode == LED_BREATHE) begin
               ramp <= ramp_nxt;
               ramp_dn <= dn_nxt;
            end
         end
      end
   end
`ifdef LED_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq;
   logic [PWM_BITS-1:0] duty_q, cnt_q;
   // square-law duty; full scale is kept so a maxed LED stays at max brightness
   always_comb begin
      sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
   end
   // gamma stage delays duty and count together so the compare stays frame-aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_q <= '0;
         cnt_q <= '0;
         pwm <= 1'b0;
      end else begin
         duty_q <= duty == DMAX ? DMAX : sq[2*PWM_BITS-1:PWM_BITS];
         cnt_q <= pwm_cnt;
         pwm <= cnt_q < duty_q;
      end
   end
`else
   // registered linear compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm <= 1'b0;
      else pwm <= pwm_cnt < duty;
   end
`endif
endmodule

// File: rtl/led_status_pwm.sv
// led_status_pwm: multi-channel LED status PWM engine with frame-aligned config (define LED_GAMMA_EN for gamma-corrected duty)
import led_status_pkg::*;
module led_status_pwm #(
   parameter int NUM_CH         = 3,
   parameter int PWM_BITS       = 8,
   parameter int PRESCALE       = 188,
   parameter int BLINK_FRAMES   = 250,
   parameter int BREATHE_FRAMES = 2,
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic                clk_48mhz,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_level,
   output logic [NUM_CH-1:0]   pwm_out,
   output logic                frame_tick
);
   localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int NPAD = 2 ** CH_W;
   logic [PS_W-1:0] pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [NUM_CH-1:0] pending;
   logic [NPAD-1:0] pend_pad;
   logic slot_tick, frame_bnd;
   assign slot_tick = pre_cnt == PS_W'(PRESCALE - 1);
   assign frame_bnd = slot_tick && pwm_cnt == '1;
   assign pend_pad = NPAD'(pending);
   assign cfg_ready = ~pend_pad[cfg_ch];
   // shared prescaler, slot counter and frame pulse
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
         frame_tick <= 1'b0;
      end else begin
         pre_cnt <= slot_tick ? '0 : pre_cnt + 1'b1;
         if (slot_tick) pwm_cnt <= pwm_cnt + 1'b1;
         frame_tick <= frame_bnd;
      end
   end
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS(PWM_BITS),
         .BLINK_FRAMES(BLINK_FRAMES),
         .BREATHE_FRAMES(BREATHE_FRAMES)
      ) u_ch (
         .clk(clk_48mhz),
         .rst(reset),
         .frame_bnd(frame_bnd),
         .we(cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
         .mode(led_mode_e'(cfg_mode)),
         .level(cfg_level),
         .pwm_cnt(pwm_cnt),
         .pending(pending[i]),
         .pwm(pwm_out[i])
      );
   end
endmodule

// File: tb/tb_led_status_pwm.sv
// tb_led_status_pwm: directed checks of config handshake, modes, reset and latency
module tb_led_status_pwm;
`ifdef LED_GAMMA_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic clk, reset, cfg_valid, cfg_ready, frame_tick;
   logic [1:0] cfg_ch, cfg_mode;
   logic [3:0] cfg_level;
   logic [2:0] pwm_out;
   int n_chk, n_pass, any_hi, ftc, w, ft;
   int hi[3], ld[3];
   bit run[3];
   led_status_pwm #(
      .NUM_CH(3), .PWM_BITS(4), .PRESCALE(2), .BLINK_FRAMES(2), .BREATHE_FRAMES(1)
   ) dut (
      .clk_48mhz(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
      .pwm_out(pwm_out), .frame_tick(frame_tick)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic int gam(input int d);
`ifdef LED_GAMMA_EN
      return d == 15 ? 15 : (d * d) >> 4;
`else
      return d;
`endif
   endfunction
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got %0d expected %0d", tag, got, exp);
   endtask
   task automatic wr(input int ch, input int mode, input int lvl, output int waits, output int ft_seen);
      int n;
      cfg_valid = 1'b1;
      cfg_ch = 2'(ch);
      cfg_mode = 2'(mode);
      cfg_level = 4'(lvl);
      #1;
      n = 0;
      ft_seen = frame_tick;
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
         ft_seen = frame_tick;
      end
      if (!cfg_ready) chk("wr_timeout", 0, 1);
      waits = n;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask
   task automatic sync_frame();
      int n;
      n = 0;
      any_hi = 0;
      do begin
         @(negedge clk);
         any_hi |= int'(|pwm_out);
         n++;
      end while (!frame_tick && n < 200);
      if (!frame_tick) chk("sync_timeout", 0, 1);
      repeat (LAT - 1) @(negedge clk);
   endtask
   task automatic meas();
      ftc = 0;
      for (int c = 0; c < 3; c++) begin
         hi[c] = 0;
         ld[c] = 0;
         run[c] = 1'b1;
      end
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         ftc += int'(frame_tick);
         for (int c = 0; c < 3; c++) begin
            if (pwm_out[c]) begin
               hi[c]++;
               if (run[c]) ld[c]++;
            end else run[c] = 1'b0;
         end
      end
   endtask
   initial begin
      int brth[8];
      brth = '{0, 1, 2, 3, 2, 1, 0, 1};
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch = '0;
      cfg_mode = '0;
      cfg_level = '0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      reset = 1'b0;
      // 1: SOLID 8 on ch0 appears only after the first boundary
      wr(0, 1, 8, w, ft);
      sync_frame();
      chk("t1_no_early", any_hi, 0);
      meas();
      chk("t1_hi", hi[0], 2 * gam(8));
      chk("t1_lead", ld[0], 2 * gam(8));
      chk("t1_tick_once", ftc, 1);
      // 2: second write to ch1 stalls until the boundary
      wr(1, 1, 4, w, ft);
      chk("t2_w1_wait", w, 0);
      wr(1, 1, 12, w, ft);
      chk("t2_w2_stalled", int'(w > 0), 1);
      chk("t2_w2_at_bnd", ft, 1);
      repeat (LAT - 1) @(negedge clk);
      meas();
      chk("t2_f1", hi[1], 2 * gam(4));
      meas();
      chk("t2_f2", hi[1], 2 * gam(12));
      // 3: BLINK 15 on ch2
      wr(2, 2, 15, w, ft);
      sync_frame();
      for (int f = 0; f < 6; f++) begin
         meas();
         chk($sformatf("t3_blink%0d", f), hi[2], (f % 4) < 2 ? 30 : 0);
         if (f == 0) chk("t3_lead", ld[2], 30);
      end
      // 4: BREATHE 3 then BREATHE 0 on ch0
      wr(0, 3, 3, w, ft);
      sync_frame();
      for (int f = 0; f < 8; f++) begin
         meas();
         chk($sformatf("t4_breathe%0d", f), hi[0], 2 * gam(brth[f]));
      end
      wr(0, 3, 0, w, ft);
      sync_frame();
      for (int f = 0; f < 3; f++) begin
         meas();
         chk($sformatf("t4_flat%0d", f), hi[0], 0);
      end
      // 5: mid-frame reset with all channels SOLID 15
      for (int c = 0; c < 3; c++) wr(c, 1, 15, w, ft);
      sync_frame();
      repeat (4) @(negedge clk);
      chk("t5_all_on", int'(pwm_out), 7);
      cfg_valid = 1'b1;
      cfg_ch = 2'd0;
      cfg_mode = 2'd0;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      chk("t5_pend_ready", int'(cfg_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t5_rst_pwm", int'(pwm_out), 0);
      chk("t5_rst_ready", int'(cfg_ready), 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wr(3, 1, 15, w, ft);
      chk("t5_ch3_accept", w, 0);
      sync_frame();
      meas();
      for (int c = 0; c < 3; c++) chk($sformatf("t5_off%0d", c), hi[c], 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
